// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the forwarding-select encodings, MD latencies and the stage-shadow record.
package hazard_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    typedef struct packed {
        logic [4:0] a_rs;
        logic [4:0] a_rt;
        logic [4:0] awrite;
        logic [1:0] tnew;
    } stage_t;

    // Tnew ages by one stage per move and never goes below zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Multiply/divide occupancy counter: loaded on a start in E, counts down to idle.
// md_busy stays high while any busy cycles remain.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy
);

    localparam int unsigned MaxCyc = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    logic [CntW-1:0] count_q;

    // A start while still busy simply reloads; the stall keeps that from happening.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (md_start) begin
            count_q <= md_div ? CntW'(DIV_CYC) : CntW'(MULT_CYC);
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign md_busy = (count_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: shadows Tnew/addresses down E/M/W and
// derives stall, E bubble and the D/E/M forwarding selects from them.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Tuse_rs,
    input  logic [1:0] Tuse_rt,
    input  logic [1:0] TnewD,
    input  logic [4:0] A_rsD,
    input  logic [4:0] A_rtD,
    input  logic [4:0] AwriteD,
    input  logic       md_useD,
    input  logic       md_startE,
    input  logic       md_divE,
    output logic       stall,
    output logic       flushE,
    output logic [1:0] fwd_rsD,
    output logic [1:0] fwd_rtD,
    output logic [1:0] fwd_rsE,
    output logic [1:0] fwd_rtE,
    output logic       fwd_rtM
);

    stage_t     e_q;
    logic [4:0] m_rt_q;
    logic [4:0] m_awrite_q;
    logic [1:0] m_tnew_q;
    logic [4:0] w_awrite_q;
    logic       md_busy;

    md_busy_tracker #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_startE),
        .md_div   (md_divE),
        .md_busy  (md_busy)
    );

    // A source stalls when its producer will not have the value by the time it is used.
    function automatic logic src_hazard(input logic [4:0] a, input logic [1:0] tuse,
                                        input logic [4:0] e_aw, input logic [1:0] e_tn,
                                        input logic [4:0] m_aw, input logic [1:0] m_tn);
        return (a != 5'd0) && (tuse != TUSE_NONE) &&
               (((a == e_aw) && (tuse < e_tn)) || ((a == m_aw) && (tuse < m_tn)));
    endfunction

    function automatic logic [1:0] fwd_sel_d(input logic [4:0] a,
                                             input logic [4:0] e_aw, input logic [1:0] e_tn,
                                             input logic [4:0] m_aw, input logic [1:0] m_tn,
                                             input logic [4:0] w_aw);
        if (a == 5'd0)                        return FWD_RF;
        else if ((a == e_aw) && (e_tn == 2'd0)) return FWD_E;
        else if ((a == m_aw) && (m_tn == 2'd0)) return FWD_M;
        else if (a == w_aw)                   return FWD_W;
        else                                  return FWD_RF;
    endfunction

    function automatic logic [1:0] fwd_sel_e(input logic [4:0] a,
                                             input logic [4:0] m_aw, input logic [1:0] m_tn,
                                             input logic [4:0] w_aw);
        if (a == 5'd0)                        return FWD_RF;
        else if ((a == m_aw) && (m_tn == 2'd0)) return FWD_M;
        else if (a == w_aw)                   return FWD_W;
        else                                  return FWD_RF;
    endfunction

    always_comb begin
        stall = src_hazard(A_rsD, Tuse_rs, e_q.awrite, e_q.tnew, m_awrite_q, m_tnew_q) |
                src_hazard(A_rtD, Tuse_rt, e_q.awrite, e_q.tnew, m_awrite_q, m_tnew_q) |
                (md_useD & (md_busy | md_startE));
        flushE  = stall;
        fwd_rsD = fwd_sel_d(A_rsD, e_q.awrite, e_q.tnew, m_awrite_q, m_tnew_q, w_awrite_q);
        fwd_rtD = fwd_sel_d(A_rtD, e_q.awrite, e_q.tnew, m_awrite_q, m_tnew_q, w_awrite_q);
        fwd_rsE = fwd_sel_e(e_q.a_rs, m_awrite_q, m_tnew_q, w_awrite_q);
        fwd_rtE = fwd_sel_e(e_q.a_rt, m_awrite_q, m_tnew_q, w_awrite_q);
        fwd_rtM = (m_rt_q != 5'd0) && (m_rt_q == w_awrite_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q        <= '0;
            m_rt_q     <= '0;
            m_awrite_q <= '0;
            m_tnew_q   <= '0;
            w_awrite_q <= '0;
        end else begin
            m_rt_q     <= e_q.a_rt;
            m_awrite_q <= e_q.awrite;
            m_tnew_q   <= tnew_dec(e_q.tnew);
            w_awrite_q <= m_awrite_q;
            if (stall) begin
                e_q <= '0;
            end else begin
                e_q.a_rs   <= A_rsD;
                e_q.a_rt   <= A_rtD;
                e_q.awrite <= AwriteD;
                e_q.tnew   <= tnew_dec(TnewD);
            end
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It takes the per-instruction Tuse/Tnew/register-address bundle produced by the D-stage decoder and carries it down private E/M/W shadow registers. It compares that state against the instruction now in D and drives the stall, E-bubble and forwarding-mux selects. It also tracks multiply/divide occupancy, so HI/LO-touching instructions stall while the unit is busy.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu start
- DIV_CYC, 10, busy cycles after a div/divu start

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- Tuse_rs  in  2  cycles until D instr reads rs; 3 = rs unused
- Tuse_rt  in  2  same for rt
- TnewD  in  2  cycles from D until the result exists (0 = no write)
- A_rsD  in  5  rs address read by D instr (0 = none)
- A_rtD  in  5  rt address read by D instr
- AwriteD  in  5  destination register of D instr (0 = none)
- md_useD  in  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- md_startE  in  1  mult/div in E launches this cycle
- md_divE  in  1  qualifies md_startE: 1 = div, 0 = mult
- stall  out  1  freeze PC and D register
- flushE  out  1  load bubble into E register (equals stall)
- fwd_rsD, fwd_rtD  out  2  D-operand select: 0 RF, 1 E, 2 M, 3 W
- fwd_rsE, fwd_rtE  out  2  E-operand select: 0 pipe reg, 2 M, 3 W
- fwd_rtM  out  1  store-data select: 0 pipe reg, 1 W

## Operation
- Shadow state per stage: E holds {A_rs, A_rt, Awrite, Tnew}; M holds {A_rt, Awrite, Tnew}; W holds {Awrite}.
- Every cycle: M ← E and W ← M. Tnew decrements saturating at 0 on each move: TnewE = sat(TnewD−1), TnewM = sat(TnewE−1).
- On stall, E is loaded with the bubble: all fields 0.
- Otherwise E ← D-stage inputs, with TnewE = sat(TnewD−1).
- Stall on a data hazard, evaluated per source s ∈ {rs, rt} with A_sD ≠ 0 and Tuse_s ≠ 3:
  - (A_sD == AwriteE && Tuse_s < TnewE), or
  - (A_sD == AwriteM && Tuse_s < TnewM).
- Stall on an MD hazard: md_useD && (md_busy || md_startE).
- stall = OR of all terms. flushE = stall.
- D forwarding, first match wins:
  - E if AwriteE == A_sD, ≠ 0 and TnewE == 0;
  - else M if AwriteM match and TnewM == 0;
  - else W if AwriteW match;
  - else RF.
- E forwarding: M if AwriteM == A_sE ≠ 0 and TnewM == 0; else W on AwriteW match; else 0.
- M forwarding: fwd_rtM = (A_rtM ≠ 0 && A_rtM == AwriteW).
- Register $0 never matches. An address of 0 disables both the compare and the forward.
- MD counter:
  - md_startE loads DIV_CYC or MULT_CYC;
  - otherwise it decrements toward 0;
  - md_busy = (count ≠ 0).
  - A start while busy reloads the counter. This cannot occur legally, because the stall prevents it.

## Timing
- All outputs are combinational from the current inputs and registered state. No added latency.
- Reset: every shadow field 0 and count 0. Hence stall = flushE = 0 and all fwd selects = 0 on the first cycle after reset, provided the D inputs request no MD op.
- Reset mid-stall or mid-MD-busy clears state at the next edge. stall deasserts that cycle unless the D inputs alone assert it through md_startE.
- Load-use (TnewD = 3 producer, Tuse = 1 consumer): exactly 1 stall cycle. For a branch consumer (Tuse = 0): 2 stall cycles.
- ALU producer (TnewD = 2) → branch consumer: 1 stall cycle. Then forward from M.
- mult in E: the following mfhi in D stalls for 1 + MULT_CYC cycles. For div: 1 + DIV_CYC cycles.
- A simultaneous E and M match uses the E-stage compare first. Stall and forward evaluate independently; when stall = 1, the fwd values are don't-care.

## Structure
- Shared package hazard_pkg:
  - TUSE_NONE = 2'd3;
  - FWD_RF / FWD_E / FWD_M / FWD_W encodings;
  - default MULT_CYC / DIV_CYC;
  - a stage-shadow struct {a_rs, a_rt, awrite, tnew}.
- One sub-module, md_busy_tracker: counter, load/decrement, md_busy output.
- Shadow registers and compare logic stay in hazard_ctrl.

## Test plan
- lw $8 (TnewD 3, Awrite 8) then add using rs = 8 (Tuse 1) → stall = 1 and flushE = 1 for one cycle. Next cycle stall = 0 and fwd_rsE = 2 (M) is not needed; fwd_rsE = 3 (W) once the load reaches W.
- addu $5 (TnewD 2) then beq rs = 5 (Tuse 0) → one stall cycle, then fwd_rsD = 2 (M).
- sw rt = 9 behind lw $9 by one instruction → no stall (Tuse_rt 2). When sw reaches M, fwd_rtM = 1.
- mult started (md_startE = 1, md_divE = 0), mfhi in D → stall high 6 cycles, low on the 7th. The same with div gives 11 cycles.
- Producer with AwriteD = 0 and consumer A_rsD = 0 → no stall, all fwd = 0.
- Assert reset during a div busy window → next cycle count = 0, stall = 0 with mfhi still in D.
